// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and a
// multi-cycle EX-stage occupancy FSM, with a fixed stall/flush priority.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4  // EX occupancy of a multi-cycle op, 2..16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic       RegWriteE,
  input  logic       LoadE,
  input  logic       PCSrcE,
  input  logic       MulStartE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MulBusy,
  output logic       MulDone
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [4:0] r_rd_m;
  logic       r_rw_m;
  logic [4:0] r_rd_w;
  logic       r_rw_w;

  logic       w_mul_stall;
  logic       w_mul_done;
  logic       w_lw_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // MEM result is newer than WB, so it wins; x0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic rw_m,
                                         input logic [4:0] rd_w, input logic rw_w);
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs))      return FWD_MEM;
    else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    else                                             return FWD_RF;
  endfunction

  assign w_fwd_a    = fwd_sel(Rs1E, r_rd_m, r_rw_m, r_rd_w, r_rw_w);
  assign w_fwd_b    = fwd_sel(Rs2E, r_rd_m, r_rw_m, r_rd_w, r_rw_w);
  assign w_lw_stall = LoadE && RegWriteE && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mul_stall = 1'b0;
    w_mul_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (MulStartE) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = CNT_INIT;
          w_mul_stall = 1'b1;
        end
      end
      BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt   = r_cnt - 4'd1;
          w_mul_stall = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_mul_done  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low during reset even though the registers still hold old state.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    MulBusy   = 1'b0;
    MulDone   = 1'b0;
    if (!reset) begin
      ForwardAE = w_fwd_a;
      ForwardBE = w_fwd_b;
      MulBusy   = (r_state == BUSY);
      MulDone   = w_mul_done;
      if (w_mul_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rd_m  <= 5'd0;
      r_rw_m  <= 1'b0;
      r_rd_w  <= 5'd0;
      r_rw_w  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_mul_stall) begin
        // The held EX instruction must not advance, so MEM receives a bubble.
        r_rd_m <= 5'd0;
        r_rw_m <= 1'b0;
      end else begin
        r_rd_m <= RdE;
        r_rw_m <= RegWriteE;
      end
      r_rd_w <= r_rd_m;
      r_rw_w <= r_rw_m;
    end
  end

endmodule
